// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-memory responder and its arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package data_mem_pkg;

  // Per-channel handshake state.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    READ_DONE  = 2'd2,
    WRITE_DONE = 2'd3
  } chan_state_t;

  // Width needed to index n channels, never less than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_CHANNELS_DEFAULT = 4;
  localparam int CHAN_IDX_BITS        = idx_bits(NUM_CHANNELS_DEFAULT);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks one requester per cycle, scanning upward from a rotating pointer.
// Latency: grant is combinational from req_i; pointer advances at the edge that consumes a grant.
// Backpressure: none; a requester simply keeps req_i high until it is granted.
module rr_arbiter
  import data_mem_pkg::*;
#(
  parameter int N        = 4,
  parameter int IDX_BITS = idx_bits(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_i,
  output logic [N-1:0]        grant_oh_o,
  output logic [IDX_BITS-1:0] grant_idx_o,
  output logic                grant_vld_o
);

  logic [IDX_BITS-1:0] ptr_q, ptr_d;
  logic [IDX_BITS:0]   cand;

  // First requester at or after the pointer wins, wrapping modulo N.
  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    cand        = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr_q} + (IDX_BITS+1)'(i);
      if (cand >= (IDX_BITS+1)'(N)) begin
        cand = cand - (IDX_BITS+1)'(N);
      end
      if (!grant_vld_o && req_i[cand[IDX_BITS-1:0]]) begin
        grant_vld_o                     = 1'b1;
        grant_idx_o                     = cand[IDX_BITS-1:0];
        grant_oh_o[cand[IDX_BITS-1:0]]  = 1'b1;
      end
    end
  end

  // Pointer moves to the channel after the winner; holds when nobody is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld_o) begin
      ptr_d = (grant_idx_o == IDX_BITS'(N - 1)) ? '0 : grant_idx_o + IDX_BITS'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: serves NUM_CHANNELS valid/ready requesters from one single-port array.
// Latency: write_ready one cycle after grant; read_ready READ_LATENCY cycles after grant.
// Backpressure: one grant per cycle (round-robin); ready held until the requester drops valid.
// Optional DATA_MEM_BACKDOOR_EN adds a preload port that pre-empts channel grants.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] read_address,
  output logic [NUM_CHANNELS-1:0]           read_ready,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] read_data,
  input  logic [NUM_CHANNELS-1:0]           write_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] write_address,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] write_data,
  output logic [NUM_CHANNELS-1:0]           write_ready
`ifdef DATA_MEM_BACKDOOR_EN
  ,
  input  logic                              load_valid,
  input  logic [ADDR_BITS-1:0]              load_address,
  input  logic [DATA_BITS-1:0]              load_data
`endif
);

  localparam int CIB   = idx_bits(NUM_CHANNELS);
  localparam int DEPTH = 2 ** ADDR_BITS;

  // One slot of the read-return pipeline: which channel, and the word read at grant.
  typedef struct packed {
    logic                 vld;
    logic [CIB-1:0]       chan;
    logic [DATA_BITS-1:0] data;
  } rd_stage_t;

  logic                 bd_vld;
  logic [ADDR_BITS-1:0] bd_addr;
  logic [DATA_BITS-1:0] bd_data;

`ifdef DATA_MEM_BACKDOOR_EN
  assign bd_vld  = load_valid;
  assign bd_addr = load_address;
  assign bd_data = load_data;
`else
  assign bd_vld  = 1'b0;
  assign bd_addr = '0;
  assign bd_data = '0;
`endif

  chan_state_t          state_q [NUM_CHANNELS];
  chan_state_t          state_d [NUM_CHANNELS];
  logic [DATA_BITS-1:0] rdata_q [NUM_CHANNELS];
  logic [DATA_BITS-1:0] rdata_d [NUM_CHANNELS];
  logic [DATA_BITS-1:0] mem_q   [DEPTH];

  logic [NUM_CHANNELS-1:0] req;
  logic [NUM_CHANNELS-1:0] grant_oh;
  logic [CIB-1:0]          grant_idx;
  logic                    grant_vld;
  logic                    g_wr;
  logic [ADDR_BITS-1:0]    g_addr;
  logic [DATA_BITS-1:0]    g_wdata;
  rd_stage_t               head;

  // A channel competes only when idle with a request, out of reset, and no preload this cycle.
  always_comb begin
    req = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      req[c] = reset && !bd_vld && (state_q[c] == IDLE) && (read_valid[c] || write_valid[c]);
    end
  end

  rr_arbiter #(
    .N        (NUM_CHANNELS),
    .IDX_BITS (CIB)
  ) u_arb (
    .clk         (clk),
    .rst_n       (reset),
    .req_i       (req),
    .grant_oh_o  (grant_oh),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld)
  );

  // Decode the winner's access; a channel holding both valids is served as a write first.
  always_comb begin
    g_wr    = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (grant_oh[c]) begin
        g_wr    = write_valid[c];
        g_addr  = write_valid[c] ? write_address[c*ADDR_BITS +: ADDR_BITS]
                                 : read_address[c*ADDR_BITS +: ADDR_BITS];
        g_wdata = write_data[c*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // Array port: preload has priority (it blocks grants anyway); contents survive reset.
  always_ff @(posedge clk) begin
    if (bd_vld) begin
      mem_q[bd_addr] <= bd_data;
    end else if (grant_vld && g_wr) begin
      mem_q[g_addr] <= g_wdata;
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      // Read completes at the grant edge itself.
      always_comb begin
        head      = '0;
        head.vld  = grant_vld && !g_wr;
        head.chan = grant_idx;
        head.data = mem_q[g_addr];
      end
    end else begin : g_pipe
      rd_stage_t pipe_q [READ_LATENCY-1];

      // Sample the array at grant and carry the word through the extra latency stages.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < READ_LATENCY - 1; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          pipe_q[0].vld  <= grant_vld && !g_wr;
          pipe_q[0].chan <= grant_idx;
          pipe_q[0].data <= mem_q[g_addr];
          for (int i = 1; i < READ_LATENCY - 1; i++) begin
            pipe_q[i] <= pipe_q[i-1];
          end
        end
      end

      // Oldest stage delivers to its channel at the coming edge.
      always_comb begin
        head = pipe_q[READ_LATENCY-2];
      end
    end
  endgenerate

  // Per-channel handshake: grant -> wait/done, done held until the matching valid drops.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      state_d[c] = state_q[c];
      rdata_d[c] = rdata_q[c];
      case (state_q[c])
        IDLE: begin
          if (grant_oh[c]) begin
            state_d[c] = g_wr ? WRITE_DONE : ((READ_LATENCY == 1) ? READ_DONE : READ_WAIT);
          end
        end
        READ_WAIT: begin
          // Completes even if valid was withdrawn meanwhile; ready then pulses one cycle.
          if (head.vld && (head.chan == CIB'(c))) begin
            state_d[c] = READ_DONE;
          end
        end
        READ_DONE: begin
          if (!read_valid[c]) begin
            state_d[c] = IDLE;
          end
        end
        WRITE_DONE: begin
          if (!write_valid[c]) begin
            state_d[c] = IDLE;
          end
        end
        default: state_d[c] = IDLE;
      endcase
      if (head.vld && (head.chan == CIB'(c))) begin
        rdata_d[c] = head.data;
      end
    end
  end

  // Channel state and returned-data registers; reset drops any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= IDLE;
        rdata_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        rdata_q[c] <= rdata_d[c];
      end
    end
  end

  // Ready flags come straight from the registered state; data is held between reads.
  always_comb begin
    read_ready  = '0;
    write_ready = '0;
    read_data   = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      read_ready[c]                       = (state_q[c] == READ_DONE);
      write_ready[c]                      = (state_q[c] == WRITE_DONE);
      read_data[c*DATA_BITS +: DATA_BITS] = rdata_q[c];
    end
  end

endmodule
